// File: rtl/vc_arbiter_pkg.sv
// Shared types and defaults for the VC arbiter: FSM state encoding, widths, index helper.
// Only the 4-VC configuration is supported, which fixes the VC index width at 2.
package vc_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 10;
  localparam int NUM_VC_DEF     = 4;
  localparam int VC_IDX_W       = 2;

  typedef logic [VC_IDX_W-1:0] vc_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } arb_state_t;

  function automatic vc_idx_t onehot_to_idx(input logic [NUM_VC_DEF-1:0] oh);
    vc_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_VC_DEF; i++) begin
      if (oh[i]) idx = vc_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first set request bit searching upward from last_gnt+1 (wrapping).
// Purely combinational; no state, no backpressure of its own.
module rr_select
  import vc_arbiter_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEF
) (
  input  logic [NUM_VC-1:0] req,
  input  vc_idx_t           last_gnt,
  output logic [NUM_VC-1:0] gnt,
  output logic              vld
);

  vc_idx_t idx;

  // Offset NUM_VC wraps back onto last_gnt itself, so it is considered last.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_VC; k++) begin
      idx = last_gnt + vc_idx_t'(k);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_arbiter.sv
// Drains NUM_VC source FIFOs into one destination FIFO, one word per cycle, round-robin per word.
// Latency 1 cycle pop->push; dst_almost_full stops pops combinationally, in-flight word still lands.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_VC     = NUM_VC_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_VC-1:0]            src_empty,
  input  logic [NUM_VC*DATA_WIDTH-1:0] src_data,
  input  logic                         dst_almost_full,
  output logic [NUM_VC-1:0]            src_pop,
  output logic                         dst_push,
  output logic [DATA_WIDTH-1:0]        dst_data,
  output logic [VC_IDX_W-1:0]          grant_vc,
  output logic                         idle
);

  arb_state_t          state_q, state_d;
  vc_idx_t             last_q;
  vc_idx_t             gnt_q;
  logic                push_q;
  logic [NUM_VC-1:0]   req;
  logic [NUM_VC-1:0]   rr_gnt;
  logic                rr_vld;
  logic                any_req;
  logic                pop_en;
  vc_idx_t             pop_idx;

  assign req     = ~src_empty;
  assign any_req = |req;

  rr_select #(
    .NUM_VC (NUM_VC)
  ) u_rr_select (
    .req      (req),
    .last_gnt (last_q),
    .gnt      (rr_gnt),
    .vld      (rr_vld)
  );

  always_comb begin
    state_d = state_q;
    pop_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req && !dst_almost_full) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (dst_almost_full) begin
          state_d = ST_PAUSE;
        end else if (!any_req) begin
          state_d = ST_IDLE;
        end else begin
          pop_en = rr_vld;
        end
      end
      ST_PAUSE: begin
        if (!dst_almost_full) state_d = any_req ? ST_ACTIVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign src_pop = pop_en ? rr_gnt : '0;
  assign pop_idx = onehot_to_idx(rr_gnt);

  // Pointer starts at the top VC so that VC0 is the first winner after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= vc_idx_t'(NUM_VC - 1);
      gnt_q   <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      push_q  <= pop_en;
      if (pop_en) begin
        last_q <= pop_idx;
        gnt_q  <= pop_idx;
      end
    end
  end

  // Source read data arrives the cycle after the pop, so mux it by the registered grant.
  always_comb begin
    dst_data = '0;
    if (push_q) begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (gnt_q == vc_idx_t'(i)) dst_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign dst_push = push_q;
  assign grant_vc = gnt_q;
  assign idle     = (state_q == ST_IDLE) && !push_q;

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 10, SHALL set the word width of every data port.
REQ-002 Parameter NUM_VC, default 4, SHALL set the number of source FIFOs; the design is only required to support 4.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset: 0 = in reset, 1 = run.
REQ-005 src_empty  input  NUM_VC  SHALL give the per-source-FIFO empty flags; bit i belongs to VC i.
REQ-006 src_data  input  NUM_VC*DATA_WIDTH  SHALL carry the source FIFO read data; VC i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 dst_almost_full  input  1  SHALL be the destination FIFO almost_full flag.
REQ-008 src_pop  output  NUM_VC  SHALL be the one-hot or zero pop strobes to the source FIFOs.
REQ-009 dst_push  output  1  SHALL be the push strobe to the destination FIFO.
REQ-010 dst_data  output  DATA_WIDTH  SHALL be the word written to the destination FIFO.
REQ-011 grant_vc  output  2  SHALL give the index of the VC whose word is currently on dst_data.
REQ-012 idle  output  1  SHALL be 1 only when the FSM is in IDLE and nothing is in flight.

Function
REQ-013 Source FIFOs have one-cycle read latency: src_data for VC i is valid in the cycle after src_pop[i].
REQ-014 The FSM SHALL have three states: IDLE, ACTIVE and PAUSE, encoded as a package enum.
REQ-015 IDLE->ACTIVE SHALL occur when any src_empty bit is 0 and dst_almost_full is 0.
REQ-016 ACTIVE->PAUSE SHALL occur when dst_almost_full is 1; PAUSE->ACTIVE when it returns to 0 and any source is non-empty.
REQ-017 ACTIVE->IDLE and PAUSE->IDLE SHALL occur when all src_empty bits are 1 and dst_almost_full is 0.
REQ-018 In ACTIVE, with dst_almost_full at 0, the arbiter SHALL assert exactly one src_pop bit per cycle for a non-empty VC; in IDLE and PAUSE src_pop SHALL be 0.
REQ-019 Selection SHALL be round-robin per word: search starts at (last granted VC + 1) mod 4 and takes the first non-empty VC.
REQ-020 A pop in cycle N SHALL produce dst_push=1 in cycle N+1, with dst_data equal to that VC's src_data and grant_vc equal to that VC's index; latency is fixed at 1 cycle.
REQ-021 dst_push SHALL be registered; dst_data SHALL be the src_data slice muxed by the registered grant index.
REQ-022 When dst_push is 0, dst_data SHALL be 0.
REQ-023 When dst_almost_full rises in the same cycle as a pop, that pop SHALL be suppressed. A word already in flight SHALL still be pushed; the destination almost_full margin of at least 1 absorbs it.
REQ-024 A VC whose src_empty is 1 SHALL never be popped, even when it is next in round-robin order.
REQ-025 With a single non-empty VC, the arbiter SHALL pop it every cycle (back-to-back) until it is empty.
REQ-026 The round-robin pointer SHALL wrap from 3 to 0 and SHALL update only on an actual pop.

Reset
REQ-027 While reset=0: src_pop=0, dst_push=0, dst_data=0, grant_vc=0, idle=1, FSM=IDLE, last-granted pointer=3 (so VC0 wins first).
REQ-028 Reset asserted mid-operation SHALL immediately discard any in-flight word; no push SHALL follow release.
REQ-029 The first pop after reset release SHALL occur no earlier than the second rising edge of clk.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, DATA_WIDTH and NUM_VC defaults, and the VC index width (2).
REQ-031 Round-robin selection SHALL be a sub-module, rr_select: NUM_VC request bits plus a last-grant index in, one-hot grant and a valid flag out, purely combinational.

Verification
REQ-032 Reset release with VC0 holding 0x001..0x009 and other VCs empty -> 9 consecutive pops, then 9 pushes with data 0x001..0x009 and grant_vc=0 at 1-cycle latency, then idle=1.
REQ-033 All four VCs non-empty (VCi holds words 0x10i..) -> grant_vc sequence 0,1,2,3,0,...; dst_data matches each VC's order.
REQ-034 dst_almost_full raised during ACTIVE -> src_pop=0 next cycle, exactly one in-flight push completes, then PAUSE; lowering it -> pops resume from the next RR VC.
REQ-035 VC1 and VC3 non-empty, VC0/VC2 empty -> grants alternate 1,3,1,3; VC0 and VC2 are never popped.
REQ-036 reset driven to 0 the cycle after a pop -> no dst_push; after release, arbitration restarts at VC0.
REQ-037 A VC whose last word is popped -> the arbiter moves to the next non-empty VC with no bubble cycle.
